// File: rtl/jelly_stream_extract_syncflag_pkg.sv
// ---------------------------------------------------------------------------
// jelly_stream_extract_syncflag_pkg
//   Shared types and constants for the sync-flag extract stage.
//   state_t         : frame tracking state (IDLE between frames, FRAME inside)
//   ERR_COUNT_WIDTH : width of the optional framing error counter
// ---------------------------------------------------------------------------
package jelly_stream_extract_syncflag_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam int ERR_COUNT_WIDTH = 16;

endpackage

// File: rtl/jelly_stream_extract_syncflag_fifo.sv
// ---------------------------------------------------------------------------
// jelly_stream_extract_syncflag_fifo
//   Small register FIFO holding the extracted per-frame side words.
//   Depth is 2**PTR_WIDTH; the head entry is shown combinationally.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   cke          : clock enable, all state frozen when 0
//   wr_en/wr_data: push request and data (ignored when full)
//   rd_en        : pop request (ignored when empty)
//   rd_data      : head entry
//   count        : number of stored entries (PTR_WIDTH+1 bits)
//   full         : count equals depth
// ---------------------------------------------------------------------------
module jelly_stream_extract_syncflag_fifo #(
    parameter int DATA_WIDTH = 2,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cke,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full
);

    localparam int                DEPTH      = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] FULL_COUNT = {1'b1, {PTR_WIDTH{1'b0}}};
    localparam logic [PTR_WIDTH:0] CNT_ZERO   = {(PTR_WIDTH+1){1'b0}};
    localparam logic [PTR_WIDTH:0] CNT_ONE    = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic                  push_s, pop_s;
    logic                  full_s;

    assign full_s  = (count_q == FULL_COUNT);
    assign full    = full_s;
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and count; pointers wrap naturally.
    always_comb begin
        push_s   = wr_en & cke & ~full_s;
        pop_s    = rd_en & cke & (count_q != CNT_ZERO);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_WIDTH{1'b0}};
            rd_ptr_q <= {PTR_WIDTH{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/jelly_stream_extract_syncflag.sv
// ---------------------------------------------------------------------------
// jelly_stream_extract_syncflag
//   Strips the added_first/added_last side words from a stream. The data
//   (first, last, user) goes through one output register; each frame's
//   {first word, last word} pair is queued in a side FIFO.
// Ports:
//   clk, reset_n, cke               : clock, async active-low reset, enable
//   s_first/s_last/s_added_*/s_user : input beat, s_valid/s_ready handshake
//   m_first/m_last/m_user           : forwarded beat, m_valid/m_ready handshake
//   m_ext_first/m_ext_last          : extracted side pair, m_ext_valid/ready
//   err_count                       : framing error counter (only with
//                                     JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN)
// ---------------------------------------------------------------------------
module jelly_stream_extract_syncflag
    import jelly_stream_extract_syncflag_pkg::*;
#(
    parameter int                     FIRST_WIDTH    = 1,
    parameter int                     LAST_WIDTH     = 1,
    parameter int                     USER_WIDTH     = 8,
    parameter int                     FIFO_PTR_WIDTH = 2,
    parameter logic [FIRST_WIDTH-1:0] DEFAULT_FIRST  = {FIRST_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cke,
    input  logic                   s_first,
    input  logic                   s_last,
    input  logic [FIRST_WIDTH-1:0] s_added_first,
    input  logic [LAST_WIDTH-1:0]  s_added_last,
    input  logic [USER_WIDTH-1:0]  s_user,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   m_first,
    output logic                   m_last,
    output logic [USER_WIDTH-1:0]  m_user,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [FIRST_WIDTH-1:0] m_ext_first,
    output logic [LAST_WIDTH-1:0]  m_ext_last,
    output logic                   m_ext_valid,
    input  logic                   m_ext_ready
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
    ,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
`endif
);

    localparam int EXT_WIDTH = FIRST_WIDTH + LAST_WIDTH;

    logic                   m_first_q, m_first_d;
    logic                   m_last_q,  m_last_d;
    logic [USER_WIDTH-1:0]  m_user_q,  m_user_d;
    logic                   m_valid_q, m_valid_d;
    state_t                 state_q,   state_d;
    logic [FIRST_WIDTH-1:0] hold_q,    hold_d;

    logic                    s_ready_s;
    logic                    accept_s;
    logic                    push_s;
    logic [FIRST_WIDTH-1:0]  fw_s;
    logic [EXT_WIDTH-1:0]    ext_rd_data_s;
    logic [FIFO_PTR_WIDTH:0] ext_count_s;
    logic                    ext_full_s;

    // A full side FIFO stalls every beat so a later last beat can never be lost.
    assign s_ready_s = cke & (~m_valid_q | m_ready) & ~ext_full_s;
    assign accept_s  = s_valid & s_ready_s;
    assign s_ready   = s_ready_s;

    assign m_first = m_first_q;
    assign m_last  = m_last_q;
    assign m_user  = m_user_q;
    assign m_valid = m_valid_q;

    assign m_ext_first = ext_rd_data_s[EXT_WIDTH-1:LAST_WIDTH];
    assign m_ext_last  = ext_rd_data_s[LAST_WIDTH-1:0];
    assign m_ext_valid = (ext_count_s != {(FIFO_PTR_WIDTH+1){1'b0}});

    // Output register: load on accept, drop valid once consumed.
    always_comb begin
        m_first_d = m_first_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        m_valid_d = m_valid_q;
        if (accept_s) begin
            m_first_d = s_first;
            m_last_d  = s_last;
            m_user_d  = s_user;
            m_valid_d = 1'b1;
        end else if (m_ready && cke) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Frame tracking: a same-beat first word takes priority over the held one.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        push_s  = 1'b0;
        fw_s    = s_first ? s_added_first : hold_q;
        if (accept_s && s_last) begin
            push_s  = 1'b1;
            state_d = IDLE;
            hold_d  = DEFAULT_FIRST;
        end else if (accept_s && s_first) begin
            state_d = FRAME;
            hold_d  = s_added_first;
        end else begin
            state_d = state_q;
        end
    end

`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
    logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                       err_inc_s;

    assign err_count = err_count_q;

    // Count first-without-last and last-without-first beats, saturating.
    always_comb begin
        err_inc_s   = accept_s & ((s_first & (state_q == FRAME)) |
                                  (s_last & ~s_first & (state_q == IDLE)));
        err_count_d = err_count_q;
        if (err_inc_s && (err_count_q != {ERR_COUNT_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + ERR_COUNT_WIDTH'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end
`endif

    // All top-level registers, including the frame FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= {USER_WIDTH{1'b0}};
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
            hold_q    <= DEFAULT_FIRST;
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
            err_count_q <= {ERR_COUNT_WIDTH{1'b0}};
`endif
        end else begin
            m_first_q <= m_first_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
            m_valid_q <= m_valid_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
            err_count_q <= err_count_d;
`endif
        end
    end

    jelly_stream_extract_syncflag_fifo #(
        .DATA_WIDTH (EXT_WIDTH),
        .PTR_WIDTH  (FIFO_PTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .wr_en   (push_s),
        .wr_data ({fw_s, s_added_last}),
        .rd_en   (m_ext_ready),
        .rd_data (ext_rd_data_s),
        .count   (ext_count_s),
        .full    (ext_full_s)
    );

endmodule

// File: tb/tb_jelly_stream_extract_syncflag.sv
module tb_jelly_stream_extract_syncflag;

    localparam int FW = 4;
    localparam int LW = 4;
    localparam int UW = 8;
    localparam logic [FW-1:0] DEF_FIRST = 4'hA;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cke;
    logic          s_first, s_last;
    logic [FW-1:0] s_added_first;
    logic [LW-1:0] s_added_last;
    logic [UW-1:0] s_user;
    logic          s_valid, s_ready;
    logic          m_first, m_last;
    logic [UW-1:0] m_user;
    logic          m_valid, m_ready;
    logic [FW-1:0] m_ext_first;
    logic [LW-1:0] m_ext_last;
    logic          m_ext_valid, m_ext_ready;
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
    logic [15:0]   err_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [UW+1:0]  exp_data_q [$];
    logic [FW+LW-1:0] exp_ext_q [$];

    always #5 clk = ~clk;

    jelly_stream_extract_syncflag #(
        .FIRST_WIDTH    (FW),
        .LAST_WIDTH     (LW),
        .USER_WIDTH     (UW),
        .FIFO_PTR_WIDTH (2),
        .DEFAULT_FIRST  (DEF_FIRST)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cke           (cke),
        .s_first       (s_first),
        .s_last        (s_last),
        .s_added_first (s_added_first),
        .s_added_last  (s_added_last),
        .s_user        (s_user),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_first       (m_first),
        .m_last        (m_last),
        .m_user        (m_user),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_ext_first   (m_ext_first),
        .m_ext_last    (m_ext_last),
        .m_ext_valid   (m_ext_valid),
        .m_ext_ready   (m_ext_ready)
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
        ,
        .err_count     (err_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one beat and hold it until accepted; record the expected output beat.
    task automatic send_beat(input logic f, input logic l, input logic [FW-1:0] af,
                             input logic [LW-1:0] al, input logic [UW-1:0] u);
        bit ok;
        ok = 1'b0;
        s_first = f; s_last = l; s_added_first = af; s_added_last = al; s_user = u;
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_data_q.push_back({f, l, u});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout user=%0h never accepted", u);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every transfer on either output port.
    initial begin
        logic [UW+1:0]    ed;
        logic [FW+LW-1:0] ee;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (m_valid && m_ready && cke) begin
                    if (exp_data_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL m_data_unexpected actual=%0h expected=none", {m_first, m_last, m_user});
                    end else begin
                        ed = exp_data_q.pop_front();
                        check("m_data", 32'({m_first, m_last, m_user}), 32'(ed));
                    end
                end
                if (m_ext_valid && m_ext_ready && cke) begin
                    if (exp_ext_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL m_ext_unexpected actual=%0h expected=none", {m_ext_first, m_ext_last});
                    end else begin
                        ee = exp_ext_q.pop_front();
                        check("m_ext", 32'({m_ext_first, m_ext_last}), 32'(ee));
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 1'b1; cke = 1'b1; m_ready = 1'b1; m_ext_ready = 1'b1;
        s_first = 1'b0; s_last = 1'b0; s_added_first = 4'h0; s_added_last = 4'h0;
        s_user = 8'h00; s_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_flags", 32'({m_first, m_last}), 32'd0);
        check("rst_m_user", 32'(m_user), 32'd0);
        check("rst_ext_valid", 32'(m_ext_valid), 32'd0);
        check("rst_ext_data", 32'({m_ext_first, m_ext_last}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Four-beat frame: side pair {1,2} appears the cycle after the last beat.
        send_beat(1'b1, 1'b0, 4'h1, 4'h0, 8'h10);
        send_beat(1'b0, 1'b0, 4'h0, 4'h0, 8'h11);
        send_beat(1'b0, 1'b0, 4'h0, 4'h0, 8'h12);
        check("ext_valid_before_last", 32'(m_ext_valid), 32'd0);
        exp_ext_q.push_back({4'h1, 4'h2});
        send_beat(1'b0, 1'b1, 4'h0, 4'h2, 8'h13);
        check("ext_valid_after_last", 32'(m_ext_valid), 32'd1);
        wait_cycles(3);

        // Single-beat frame.
        exp_ext_q.push_back({4'h5, 4'h6});
        send_beat(1'b1, 1'b1, 4'h5, 4'h6, 8'h20);
        wait_cycles(2);
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
        check("err_none", 32'(err_count), 32'd0);
`endif

        // Last with no first reports the default first word.
        exp_ext_q.push_back({DEF_FIRST, 4'h3});
        send_beat(1'b0, 1'b1, 4'h0, 4'h3, 8'h30);
        wait_cycles(2);
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
        check("err_missing_first", 32'(err_count), 32'd1);
`endif

        // Fill the side FIFO with the consumer stalled.
        m_ext_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_ext_q.push_back({4'(i + 1), 4'(i + 8)});
            send_beat(1'b1, 1'b1, 4'(i + 1), 4'(i + 8), 8'(8'h50 + i));
        end
        check("fifo_count_full", 32'(dut.ext_count_s), 32'd4);
        check("full_s_ready", 32'(s_ready), 32'd0);
        s_first = 1'b1; s_last = 1'b1; s_added_first = 4'h5; s_added_last = 4'hC;
        s_user = 8'h58; s_valid = 1'b1;
        @(negedge clk);
        check("full_stall", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        m_ext_ready = 1'b1;
        @(negedge clk);
        check("full_stall_pop_cycle", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        m_ext_ready = 1'b0;
        @(negedge clk);
        check("accept_after_pop", 32'(s_ready), 32'd1);
        exp_data_q.push_back({1'b1, 1'b1, 8'h58});
        exp_ext_q.push_back({4'h5, 4'hC});
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("fifo_count_refill", 32'(dut.ext_count_s), 32'd4);
        m_ext_ready = 1'b1;
        wait_cycles(8);

        // Output stall, then clock-enable freeze in the middle of a frame.
        m_ready = 1'b0;
        send_beat(1'b1, 1'b0, 4'h4, 4'h0, 8'h40);
        check("stall_s_ready", 32'(s_ready), 32'd0);
        wait_cycles(2);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_m_user", 32'(m_user), 32'h40);
        cke = 1'b0;
        m_ready = 1'b1;
        #1;
        check("cke_s_ready", 32'(s_ready), 32'd0);
        wait_cycles(2);
        check("cke_m_valid", 32'(m_valid), 32'd1);
        check("cke_m_user", 32'(m_user), 32'h40);
        cke = 1'b1;
        exp_ext_q.push_back({4'h4, 4'h5});
        send_beat(1'b0, 1'b1, 4'h0, 4'h5, 8'h41);
        wait_cycles(3);

        // Asynchronous reset mid-frame discards the held first word.
        send_beat(1'b1, 1'b0, 4'h6, 4'h0, 8'h60);
        reset_n = 1'b0;
        #1;
        check("areset_m_valid", 32'(m_valid), 32'd0);
        check("areset_m_user", 32'(m_user), 32'd0);
        check("areset_ext_valid", 32'(m_ext_valid), 32'd0);
        exp_data_q.delete();
        exp_ext_q.delete();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        exp_ext_q.push_back({DEF_FIRST, 4'h7});
        send_beat(1'b0, 1'b1, 4'h0, 4'h7, 8'h61);
        wait_cycles(3);
`ifdef JELLY_STREAM_EXTRACT_SYNCFLAG_ERR_EN
        check("err_after_reset", 32'(err_count), 32'd1);
`endif

        for (int i = 0; i < 50 && (exp_data_q.size() != 0 || exp_ext_q.size() != 0); i++) begin
            wait_cycles(1);
        end
        check("drain_data", 32'(exp_data_q.size()), 32'd0);
        check("drain_ext", 32'(exp_ext_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
